// File: rtl/corelet_ctrl_pkg.sv
// corelet_ctrl_pkg: shared state encoding, PE-array instructions and address widths
package corelet_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, W_LOAD, W_KERN, A_LOAD, EXEC, DRAIN, DONE} state_t;
  localparam logic [2:0] INST_IDLE  = 3'b000;
  localparam logic [2:0] INST_KLOAD = 3'b001;
  localparam logic [2:0] INST_EXEC  = 3'b010;
  localparam int XADDR_W = 11;
  localparam int PADDR_W = 11;
endpackage

// File: rtl/ctrl_skid_reg.sv
// ctrl_skid_reg: one-entry skid between xmem read data and the L0 write port
module ctrl_skid_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         ready,
  input  logic [W-1:0] din,
  output logic         wr,
  output logic [W-1:0] dout
);
  logic         pend;
  logic         full;
  logic [W-1:0] skid;
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
      full <= 1'b0;
      skid <= '0;
    end else begin
      pend <= rd;
      if (pend && !ready) begin
        full <= 1'b1;
        skid <= din;
      end else if (ready) begin
        full <= 1'b0;
      end
    end
  end
  always_comb begin
    wr   = ready && (pend || full);
    dout = !wr ? '0 : full ? skid : din;
  end
endmodule

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: job sequencer for xmem->L0->PE array->OFIFO->pmem; CORELET_CTRL_OVERLAP_DRAIN_EN also drains during EXEC
module corelet_ctrl
  import corelet_ctrl_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int row     = 8,
  parameter int len     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     xmem_cen,
  output logic [XADDR_W-1:0]       xmem_addr,
  input  logic [bw*row-1:0]        xmem_rdata,
  output logic                     l0_wr,
  output logic                     l0_rd,
  output logic [bw*row-1:0]        l0_wdata,
  input  logic                     l0_ready,
  output logic [2:0]               inst_w,
  input  logic                     ofifo_valid,
  output logic                     ofifo_rd,
  input  logic [psum_bw*col-1:0]   ofifo_rdata,
  output logic                     pmem_wen,
  output logic [PADDR_W-1:0]       pmem_addr,
  output logic [psum_bw*col-1:0]   pmem_wdata
);
  localparam int CW = $clog2(len + 1);
  localparam logic [CW-1:0] COL_C = CW'(col);
  localparam logic [CW-1:0] COL_L = CW'(col - 1);
  localparam logic [CW-1:0] LEN_C = CW'(len);
  localparam logic [CW-1:0] LEN_L = CW'(len - 1);
  state_t        state, state_n;
  logic [CW-1:0] cnt, rd_cnt, pop_cnt;
  logic          load, rd, pop, pop_st;
  ctrl_skid_reg #(.W(bw*row)) u_skid (
    .clk   (clk),
    .reset (reset),
    .rd    (rd),
    .ready (l0_ready),
    .din   (xmem_rdata),
    .wr    (l0_wr),
    .dout  (l0_wdata)
  );
  always_comb begin
    load = state == W_LOAD || state == A_LOAD;
    rd   = load && l0_ready && rd_cnt < (state == W_LOAD ? COL_C : LEN_C);
`ifdef CORELET_CTRL_OVERLAP_DRAIN_EN
    pop_st = state == EXEC || state == DRAIN;
`else
    pop_st = state == DRAIN;
`endif
    pop = pop_st && ofifo_valid && pop_cnt < LEN_C;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? W_LOAD : IDLE;
      W_LOAD:  state_n = l0_wr && cnt == COL_L ? W_KERN : W_LOAD;
      W_KERN:  state_n = cnt == COL_L ? A_LOAD : W_KERN;
      A_LOAD:  state_n = l0_wr && cnt == LEN_L ? EXEC : A_LOAD;
      EXEC:    state_n = cnt == LEN_L ? DRAIN : EXEC;
      DRAIN:   state_n = pop_cnt == LEN_C || (pop && pop_cnt == LEN_L) ? DONE : DRAIN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_cnt  <= '0;
      pop_cnt <= '0;
    end else begin
      state   <= state_n;
      cnt     <= state_n != state ? '0 : cnt + CW'((load && l0_wr) || state == W_KERN || state == EXEC);
      rd_cnt  <= state_n != state ? '0 : rd_cnt + CW'(rd);
      // pops taken during EXEC carry into DRAIN
      pop_cnt <= state_n != state && state_n != DRAIN ? '0 : pop_cnt + CW'(pop);
    end
  end
  always_comb begin
    busy       = state != IDLE || start;
    done       = state == DONE;
    xmem_cen   = !rd;
    xmem_addr  = load ? XADDR_W'(rd_cnt) + (state == A_LOAD ? XADDR_W'(col) : XADDR_W'(0)) : '0;
    l0_rd      = state == W_KERN || state == EXEC;
    inst_w     = state == W_KERN ? INST_KLOAD : state == EXEC ? INST_EXEC : INST_IDLE;
    ofifo_rd   = pop;
    pmem_wen   = !pop;
    pmem_addr  = pop ? PADDR_W'(pop_cnt) : '0;
    pmem_wdata = pop ? ofifo_rdata : '0;
  end
endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: table-driven job scenarios with xmem/array models and L0/pmem scoreboards
module tb_corelet_ctrl;
  import corelet_ctrl_pkg::*;
  localparam int BW = 4, PB = 16, COL = 8, ROW = 8, LEN = 16;
  logic clk = 1'b0;
  logic reset, start, l0_ready, ofifo_valid;
  logic [BW*ROW-1:0] xmem_rdata, l0_wdata;
  logic [PB*COL-1:0] ofifo_rdata, pmem_wdata;
  logic busy, done, xmem_cen, l0_wr, l0_rd, ofifo_rd, pmem_wen;
  logic [10:0] xmem_addr, pmem_addr;
  logic [2:0] inst_w;
  always #5 clk = ~clk;
  corelet_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .xmem_cen(xmem_cen), .xmem_addr(xmem_addr), .xmem_rdata(xmem_rdata),
    .l0_wr(l0_wr), .l0_rd(l0_rd), .l0_wdata(l0_wdata), .l0_ready(l0_ready),
    .inst_w(inst_w), .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .ofifo_rdata(ofifo_rdata),
    .pmem_wen(pmem_wen), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata)
  );
  typedef struct {
    string nm;
    int    stall_at;
    int    dstall;
    bit    sbusy;
    bit    gate;
    int    e_l0, e_k, e_e, e_pm, e_dn;
  } vec_t;
  vec_t v[5];
  int n_cmp = 0, n_err = 0;
  logic [31:0]  exp_l0[$];
  logic [138:0] exp_pm[$];
  logic [127:0] afifo[$];
  int l0n, kn, en, pmn, dn, xpops, pushed, stall_run, sl, dl;
  bit did_stall, did_d, did_s, dhold, mon_en;
  int cfg_stall_at, cfg_dstall;
  bit cfg_sbusy, cfg_gate;
  logic [10:0] stall_addr;
  logic m_cen = 1'b1, m_ofrd = 1'b0;
  logic [10:0] m_addr = '0;
  logic [2:0] m_inst = '0;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] xdat(input int a);
    return 32'(a) * 32'h0103_0507 ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [127:0] psum(input int k);
    logic [127:0] r;
    for (int c = 0; c < COL; c++) r[c*16 +: 16] = 16'(k * 256 + c * 17 + 1);
    return r;
  endfunction

  always @(negedge clk) begin
    m_cen = xmem_cen; m_addr = xmem_addr; m_inst = inst_w; m_ofrd = ofifo_rd;
    if (mon_en && !reset) begin
      if (l0_wr) begin
        check("l0_expected_write", exp_l0.size() > 0, 1);
        if (exp_l0.size() > 0) check("l0_wdata", l0_wdata, exp_l0.pop_front());
        l0n++;
      end
      if (!pmem_wen) begin
        check("pmem_expected_write", exp_pm.size() > 0, 1);
        if (exp_pm.size() > 0) check("pmem_addr_data", {pmem_addr, pmem_wdata}, exp_pm.pop_front());
        pmn++;
        if (inst_w == INST_EXEC) xpops++;
      end
      if (ofifo_rd) check("ofifo_rd_needs_valid", ofifo_valid, 1);
      if (dhold) begin
        check("drain_stall_ofifo_rd", ofifo_rd, 0);
        check("drain_stall_pmem_wen", pmem_wen, 1);
      end
      if (inst_w == INST_KLOAD) begin
        kn++;
        check("kload_l0_rd", l0_rd, 1);
        check("kload_after_weights", l0n, COL);
      end
      if (inst_w == INST_EXEC) begin
        en++;
        check("exec_l0_rd", l0_rd, 1);
        check("exec_after_acts", l0n, COL + LEN);
      end
      if (done) begin
        dn++;
        check("done_busy", busy, 1);
      end
      if (!l0_ready && busy) begin
        check("stall_no_read", xmem_cen, 1);
        if (stall_run > 0) check("stall_addr_hold", xmem_addr, stall_addr);
        else stall_addr = xmem_addr;
        stall_run++;
      end else stall_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    if (m_cen === 1'b0) xmem_rdata = xdat(int'(m_addr));
    if (m_ofrd === 1'b1 && afifo.size() > 0) void'(afifo.pop_front());
    if (m_inst === INST_EXEC) begin
      afifo.push_back(psum(pushed));
      exp_pm.push_back({11'(pushed), psum(pushed)});
      pushed++;
    end
    if (cfg_stall_at >= 0 && !did_stall && l0n == cfg_stall_at) begin
      l0_ready = 1'b0; sl = 3; did_stall = 1'b1;
    end else if (sl > 0) begin
      sl--;
      if (sl == 0) l0_ready = 1'b1;
    end
    if (cfg_dstall > 0 && !did_d && en == LEN && pmn >= 4 && pmn < LEN) begin
      dhold = 1'b1; dl = cfg_dstall; did_d = 1'b1;
    end else if (dl > 0) begin
      dl--;
      if (dl == 0) dhold = 1'b0;
    end
    if (cfg_sbusy && !did_s && en == 5) begin
      start = 1'b1; did_s = 1'b1;
    end
    ofifo_valid = afifo.size() > 0 && !dhold && (!cfg_gate || en >= 9);
    ofifo_rdata = afifo.size() > 0 ? afifo[0] : '0;
  endtask

  task automatic init_job(input vec_t t);
    exp_l0.delete(); exp_pm.delete(); afifo.delete();
    l0n = 0; kn = 0; en = 0; pmn = 0; dn = 0; xpops = 0; pushed = 0;
    sl = 0; dl = 0; did_stall = 0; did_d = 0; did_s = 0; dhold = 0;
    cfg_stall_at = t.stall_at; cfg_dstall = t.dstall; cfg_sbusy = t.sbusy; cfg_gate = t.gate;
    l0_ready = 1'b1; ofifo_valid = 1'b0; ofifo_rdata = '0;
    for (int a = 0; a < COL + LEN; a++) exp_l0.push_back(xdat(a));
    start = 1'b1;
    #1;
    check({t.nm, "_busy_on_start"}, busy, 1);
  endtask

  task automatic run_job(input vec_t t);
    init_job(t);
    for (int c = 0; c < 600 && dn == 0; c++) tick();
    check({t.nm, "_done_seen"}, dn > 0, 1);
    repeat (4) tick();
    check({t.nm, "_l0_writes"}, l0n, t.e_l0);
    check({t.nm, "_kload_cycles"}, kn, t.e_k);
    check({t.nm, "_exec_cycles"}, en, t.e_e);
    check({t.nm, "_pmem_writes"}, pmn, t.e_pm);
    check({t.nm, "_done_count"}, dn, t.e_dn);
    check({t.nm, "_l0_queue_left"}, exp_l0.size(), 0);
    check({t.nm, "_pmem_queue_left"}, exp_pm.size(), 0);
    check({t.nm, "_idle_busy"}, busy, 0);
`ifdef CORELET_CTRL_OVERLAP_DRAIN_EN
    check({t.nm, "_exec_pops_present"}, xpops > 0, 1);
`else
    check({t.nm, "_exec_pops_none"}, xpops, 0);
`endif
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_xmem_cen"}, xmem_cen, 1);
    check({tag, "_xmem_addr"}, xmem_addr, 0);
    check({tag, "_l0_wr"}, l0_wr, 0);
    check({tag, "_l0_rd"}, l0_rd, 0);
    check({tag, "_l0_wdata"}, l0_wdata, 0);
    check({tag, "_inst_w"}, inst_w, INST_IDLE);
    check({tag, "_ofifo_rd"}, ofifo_rd, 0);
    check({tag, "_pmem_wen"}, pmem_wen, 1);
    check({tag, "_pmem_addr"}, pmem_addr, 0);
    check({tag, "_pmem_wdata"}, pmem_wdata, 0);
  endtask

  initial begin
    v[0] = '{"nominal",   -1, 0,  1'b0, 1'b0, 24, 8, 16, 16, 1};
    v[1] = '{"backpress",  5, 0,  1'b0, 1'b0, 24, 8, 16, 16, 1};
    v[2] = '{"drainstall", -1, 10, 1'b0, 1'b0, 24, 8, 16, 16, 1};
    v[3] = '{"startbusy", -1, 0,  1'b1, 1'b0, 24, 8, 16, 16, 1};
    v[4] = '{"lategate",  -1, 0,  1'b0, 1'b1, 24, 8, 16, 16, 1};
    reset = 1'b1; start = 1'b0; l0_ready = 1'b1; ofifo_valid = 1'b0;
    ofifo_rdata = '0; xmem_rdata = '0; mon_en = 1'b0;
    cfg_stall_at = -1; cfg_dstall = 0; cfg_sbusy = 0; cfg_gate = 0;
    l0n = 0; kn = 0; en = 0; pmn = 0; dn = 0; xpops = 0; pushed = 0;
    sl = 0; dl = 0; stall_run = 0; dhold = 0; did_stall = 0; did_d = 0; did_s = 0;
    repeat (3) tick();
    check_reset_outs("por");
    reset = 1'b0;
    mon_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) run_job(v[i]);
    init_job(v[0]);
    for (int c = 0; c < 200 && l0n < 12; c++) tick();
    check("abort_reached_aload", l0n >= 12, 1);
    reset = 1'b1;
    tick();
    check_reset_outs("abort");
    reset = 1'b0;
    repeat (3) tick();
    check("abort_no_done", dn, 0);
    check("abort_no_exec", en, 0);
    run_job(v[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
